// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns a core load/store into a registered req/gnt/rvalid word access.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses (adds the misalign output).
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        stall,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       f3_reg;
  logic [1:0]       off_reg;
  logic             err_reg, trap_reg;

  logic        legal_f3, request, timeout_hit;
  logic        issue, trap, finish_ok, finish_err;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, load_ext;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Stores take priority, so a store-only func3 check applies whenever mem_write is high.
  always_comb begin
    legal_f3 = 1'b0;
    if (mem_write)
      legal_f3 = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    else if (mem_read)
      legal_f3 = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                 (func3 == 3'b100) || (func3 == 3'b101);
  end

  assign request     = (mem_read | mem_write) & legal_f3;
  assign stall       = request & (state_reg != ST_DONE);
  assign timeout_hit = TIMEOUT_EN && ((cnt_reg + CNT_W'(1)) == TIMEOUT_VAL);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                      ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign misalign   = (state_reg == ST_DONE) & trap_reg;
`endif

  assign rdata_valid = (state_reg == ST_DONE) & ~err_reg & ~trap_reg;
  assign bus_err     = (state_reg == ST_DONE) & err_reg;

  // func3[1:0] encodes the access width for loads and stores alike.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = write_data;
    case (func3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_val = 8'(m_rdata >> {off_reg, 3'b000});
  assign half_val = 16'(m_rdata >> {off_reg[1], 4'b0000});

  always_comb begin
    case (f3_reg)
      3'b000:  load_ext = {{24{byte_val[7]}}, byte_val};
      3'b001:  load_ext = {{16{half_val[15]}}, half_val};
      3'b100:  load_ext = {24'h0, byte_val};
      3'b101:  load_ext = {16'h0, half_val};
      default: load_ext = m_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    trap       = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (request) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            trap       = 1'b1;
            state_next = ST_DONE;
          end else begin
            issue      = 1'b1;
            state_next = ST_REQ;
          end
`else
          issue      = 1'b1;
          state_next = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (timeout_hit) begin
          finish_err = 1'b1;
          state_next = ST_DONE;
        end else if (m_gnt) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving in the final allowed cycle still completes normally.
        if (m_rvalid) begin
          finish_ok  = 1'b1;
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          finish_err = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_be      <= '0;
      m_wdata   <= '0;
      f3_reg    <= '0;
      off_reg   <= '0;
      err_reg   <= 1'b0;
      trap_reg  <= 1'b0;
      rdata     <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= finish_err;
      trap_reg  <= trap;

      if (issue) begin
        m_req   <= 1'b1;
        m_we    <= mem_write;
        m_addr  <= {addr[31:2], 2'b00};
        m_be    <= be_next;
        m_wdata <= wdata_next;
        f3_reg  <= func3;
        off_reg <= addr[1:0];
      end else if ((state_reg == ST_REQ) && (state_next != ST_REQ)) begin
        m_req <= 1'b0;
      end

      if ((state_reg == ST_REQ) || (state_reg == ST_WAIT))
        cnt_reg <= cnt_reg + CNT_W'(1);
      else
        cnt_reg <= '0;

      if (finish_ok)
        rdata <= m_we ? 32'h0 : load_ext;
      else if (finish_err || trap ||
               ((state_reg == ST_IDLE) && (mem_read | mem_write) && !legal_f3))
        rdata <= 32'h0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed accesses against a small req/gnt/rvalid memory.
module tb_lsu_mem_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, write_data;
  logic [31:0] rdata;
  logic        rdata_valid, stall, bus_err;
  logic        m_req, m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  logic        mis_sig;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign mis_sig = misalign;
`else
  assign mis_sig = 1'b0;
`endif

  always #5 clk = ~clk;

  lsu_mem_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
    .addr(addr), .write_data(write_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          stalls;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int n_vec = 0;
  int n_err = 0;

  int          cfg_gd = 0, cfg_rvd = 0;
  bit          cfg_never = 1'b0;
  bit          inject_rv = 1'b0;
  logic [31:0] mem_word = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory: grant after cfg_gd REQ cycles, respond cfg_rvd cycles into WAIT.
  initial begin
    int g_wait, r_wait;
    bit r_arm;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    g_wait = 0; r_wait = 0; r_arm = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
      if (rst) begin
        g_wait = 0; r_arm = 1'b0;
      end else begin
        if (inject_rv) begin
          m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; inject_rv = 1'b0;
        end
        if (r_arm) begin
          if (r_wait >= cfg_rvd) begin
            r_arm = 1'b0;
            if (!cfg_never) begin m_rvalid = 1'b1; m_rdata = mem_word; end
          end else r_wait++;
        end
        if (m_req) begin
          if (g_wait >= cfg_gd) begin
            m_gnt = 1'b1; g_wait = 0; r_arm = 1'b1; r_wait = 0;
          end else g_wait++;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT issues a request or completes.
  bit          req_prev = 1'b0;
  int          stall_cnt = 0;
  req_t        er;
  rsp_t        es;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;

  always @(negedge clk) begin
    if (rst) begin
      req_prev  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (m_req && !req_prev) begin
        if (exp_req_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: m_addr=0x%08h issued with nothing pending", m_addr);
        end else begin
          er = exp_req_q.pop_front();
          check("m_we", 32'(m_we), 32'(er.we));
          check("m_addr", m_addr, er.addr);
          check("m_be", 32'(m_be), 32'(er.be));
          if (er.we) check("m_wdata", m_wdata, er.wdata);
        end
        snap_we = m_we; snap_addr = m_addr; snap_be = m_be; snap_wdata = m_wdata;
      end else if (m_req) begin
        check("m_we_hold", 32'(m_we), 32'(snap_we));
        check("m_addr_hold", m_addr, snap_addr);
        check("m_be_hold", 32'(m_be), 32'(snap_be));
        check("m_wdata_hold", m_wdata, snap_wdata);
      end
      req_prev = m_req;

      if (rdata_valid || bus_err || mis_sig) begin
        if (exp_rsp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rsp: rdata_valid=%0b bus_err=%0b rdata=0x%08h", rdata_valid, bus_err, rdata);
        end else begin
          es = exp_rsp_q.pop_front();
          check("rdata", rdata, es.rdata);
          check("bus_err", 32'(bus_err), 32'(es.err));
          check("rdata_valid", 32'(rdata_valid), 32'(!(es.err || es.mis)));
`ifdef MISALIGN_TRAP_EN
          check("misalign", 32'(mis_sig), 32'(es.mis));
`endif
          check("stall_cycles", stall_cnt, es.stalls);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic wait_done();
    int k = 0;
    do begin @(negedge clk); k++; end while (!(rdata_valid || bus_err || mis_sig) && k < 64);
    if (!(rdata_valid || bus_err || mis_sig)) begin
      n_vec++; n_err++;
      $display("FAIL done_wait: no completion within 64 cycles, got none, expected a DONE pulse");
    end
  endtask

  task automatic wait_req();
    int k = 0;
    do begin @(negedge clk); k++; end while (!m_req && k < 16);
    if (!m_req) begin
      n_vec++; n_err++;
      $display("FAIL req_wait: m_req=0 after 16 cycles, expected 1");
    end
  endtask

  task automatic drop_inputs();
    @(posedge clk); #2;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int gd, input int rvd, input logic [3:0] be,
                        input logic [31:0] wdat, input logic [31:0] exp_rd, input logic err);
    @(posedge clk); #2;
    cfg_gd = gd; cfg_rvd = rvd; cfg_never = err; mem_word = word;
    exp_req_q.push_back('{we: wr, addr: {a[31:2], 2'b00}, be: be, wdata: wdat});
    exp_rsp_q.push_back('{rdata: exp_rd, err: err, mis: 1'b0, stalls: (err ? 1 + TO : 3 + gd + rvd)});
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; write_data = wd;
    wait_done();
    drop_inputs();
    $display("access rd=%0b wr=%0b f3=%03b addr=0x%08h -> rdata=0x%08h bus_err=%0b", rd, wr, f3, a, rdata, bus_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000; addr = 32'h0; write_data = 32'h0;
    @(negedge clk);
    check("rst_m_req", 32'(m_req), 32'h0);
    check("rst_m_we", 32'(m_we), 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_be", 32'(m_be), 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    #2 rst = 1'b0;

    //     rd    wr    f3      addr          wdata         mem word      gd rvd be       m_wdata       rdata         err
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 0, 0, 4'b1100, 32'h0,        32'h0000_80FF, 1'b0);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h80FF_7F01, 0, 0, 4'b0011, 32'h0,        32'h0000_7F01, 1'b0);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 0, 0, 4'b0100, 32'h0,        32'h0000_00FF, 1'b0);
    access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 32'h0,        0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0);
    access(1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0);
    access(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h1122_3344, 32'h0,        1, 2, 4'b1111, 32'h1122_3344, 32'h0,        1'b0);

`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #2;
    exp_rsp_q.push_back('{rdata: 32'h0, err: 1'b0, mis: 1'b1, stalls: 1});
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0102;
    wait_done();
    drop_inputs();
    $display("access LW addr=0x00000102 -> misalign=%0b rdata=0x%08h", mis_sig, rdata);
`else
    access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h89AB_CDEF, 0, 0, 4'b1111, 32'h0,        32'h89AB_CDEF, 1'b0);
`endif

    access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 3, 1, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h5555_5555, 0, 0, 4'b1111, 32'h0,        32'h0,        1'b1);

    // A late response after the timeout must not complete anything.
    cfg_never = 1'b0;
    inject_rv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rv_valid", 32'(rdata_valid), 32'h0);
      check("late_rv_rdata", rdata, 32'h0);
    end
    $display("late rvalid after timeout -> rdata_valid=%0b rdata=0x%08h", rdata_valid, rdata);

    access(1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'h0,        32'h8000_1234, 0, 0, 4'b1100, 32'h0,        32'hFFFF_8000, 1'b0);

    // Reset while a request is outstanding.
    @(posedge clk); #2;
    cfg_gd = 1000; cfg_never = 1'b1;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h0000_0500, be: 4'b1111, wdata: 32'h0});
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0500;
    wait_req();
    #2 rst = 1'b1;
    #1;
    check("rst_req_m_req", 32'(m_req), 32'h0);
    check("rst_req_m_addr", m_addr, 32'h0);
    check("rst_req_rdata", rdata, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); @(negedge clk); #2 rst = 1'b0;
    cfg_gd = 0;
    $display("reset in REQ -> m_req=%0b m_addr=0x%08h", m_req, m_addr);

    // Reset while waiting for the response.
    @(posedge clk); #2;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h0000_0504, be: 4'b1111, wdata: 32'h0});
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0504;
    wait_req();
    @(negedge clk);
    check("wait_entry_m_req", 32'(m_req), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("rst_wait_m_req", 32'(m_req), 32'h0);
    check("rst_wait_valid", 32'(rdata_valid), 32'h0);
    mem_read = 1'b0;
    @(posedge clk); @(negedge clk); #2 rst = 1'b0;
    cfg_never = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(rdata_valid), 32'h0);
      check("post_rst_bus_err", 32'(bus_err), 32'h0);
    end
    $display("reset in WAIT -> m_req=%0b rdata_valid=%0b", m_req, rdata_valid);

    // Illegal func3 for a load and for a store: no access, no stall.
    @(posedge clk); #2;
    mem_read = 1'b1; func3 = 3'b011; addr = 32'h0000_0600;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("illegal_ld_stall", 32'(stall), 32'h0);
      check("illegal_ld_m_req", 32'(m_req), 32'h0);
    end
    @(posedge clk); #2;
    mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("illegal_st_stall", 32'(stall), 32'h0);
      check("illegal_st_m_req", 32'(m_req), 32'h0);
    end
    drop_inputs();
    $display("illegal func3 -> stall=%0b m_req=%0b", stall, m_req);

    access(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_00FE, 0, 0, 4'b0001, 32'h0,        32'hFFFF_FFFE, 1'b0);

    repeat (3) @(negedge clk);
    check("req_q_empty", exp_req_q.size(), 32'h0);
    check("rsp_q_empty", exp_rsp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
